// File: rtl/lcd_driver.sv
// rtl/lcd_driver.sv - HD44780 4-bit write-only driver: power-up init, then 32-char frame writes on refresh.
module lcd_driver #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12,
  parameter int T_NIBBLE  = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refresh,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [3:0]   lcd_dat
);

  localparam int CW = 24;

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, CFG, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  typedef enum logic [2:0] {PH_NONE, PH_SETUP, PH_EHIGH, PH_GAP, PH_WAIT} phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic [CW-1:0]  cnt, cnt_n, cnt_last, post_last;
  logic [4:0]     idx, idx_n;
  logic           lo, lo_n, pending, pending_n, single, e_n, rs_n;
  logic [3:0]     dat_n;
  logic [7:0]     nb;
  logic [255:0]   frame, frame_n;

  function automatic logic [7:0] byte_of(state_t st, logic [4:0] i, logic [255:0] frm);
    logic [7:0] base;
    logic [7:0] b;
    base = 8'd255 - {i, 3'b000};
    case (st)
      INIT_NIB: b = (i == 5'd3) ? 8'h02 : 8'h03;
      CFG: begin
        case (i[1:0])
          2'd0:    b = 8'h28;
          2'd1:    b = 8'h06;
          2'd2:    b = 8'h0C;
          default: b = 8'h01;
        endcase
      end
      ADDR1:        b = 8'h80;
      ADDR2:        b = 8'hC0;
      LINE1, LINE2: b = frm[base -: 8];
      default:      b = 8'h00;
    endcase
    return b;
  endfunction

  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

  // Init nibbles 1-2 and the clear command need the long wait.
  always_comb begin
    single    = (state == INIT_NIB);
    post_last = CW'(T_CMD - 1);
    if ((state == INIT_NIB && idx < 5'd2) || (state == CFG && idx == 5'd3))
      post_last = CW'(T_CLEAR - 1);
    case (phase)
      PH_SETUP: cnt_last = CW'(T_SETUP - 1);
      PH_EHIGH: cnt_last = CW'(T_EPULSE - 1);
      PH_GAP:   cnt_last = CW'(T_NIBBLE - 1);
      PH_WAIT:  cnt_last = post_last;
      default:  cnt_last = CW'(T_POWERUP - 1);
    endcase
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    lo_n      = lo;
    frame_n   = frame;
    pending_n = pending | (refresh && state != IDLE);
    case (state)
      PWR_WAIT: begin
        if (cnt == cnt_last) begin
          state_n = INIT_NIB;
          phase_n = PH_SETUP;
          cnt_n   = '0;
          idx_n   = '0;
          lo_n    = 1'b0;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (pending || refresh) begin
          frame_n   = strdata;
          pending_n = 1'b0;
          state_n   = ADDR1;
          phase_n   = PH_SETUP;
          idx_n     = '0;
          lo_n      = 1'b0;
        end
      end
      default: begin
        if (cnt == cnt_last) begin
          cnt_n = '0;
          case (phase)
            PH_SETUP: phase_n = PH_EHIGH;
            PH_EHIGH: phase_n = (single || lo) ? PH_WAIT : PH_GAP;
            PH_GAP: begin
              phase_n = PH_SETUP;
              lo_n    = 1'b1;
            end
            PH_WAIT: begin
              phase_n = PH_SETUP;
              lo_n    = 1'b0;
              idx_n   = idx + 5'd1;
              case (state)
                INIT_NIB: if (idx == 5'd3) begin state_n = CFG; idx_n = '0; end
                CFG:      if (idx == 5'd3) begin state_n = IDLE; phase_n = PH_NONE; end
                ADDR1:    begin state_n = LINE1; idx_n = '0; end
                LINE1:    if (idx == 5'd15) state_n = ADDR2;
                ADDR2:    begin state_n = LINE2; idx_n = idx; end
                LINE2:    if (idx == 5'd31) begin state_n = IDLE; phase_n = PH_NONE; end
                default:  state_n = state;
              endcase
            end
            default: phase_n = PH_SETUP;
          endcase
        end
      end
    endcase

    // RS/DAT only change on entry to a setup phase, never while E is high or falling.
    e_n   = (phase_n == PH_EHIGH);
    rs_n  = lcd_rs;
    dat_n = lcd_dat;
    nb    = byte_of(state_n, idx_n, frame_n);
    if (phase_n == PH_SETUP) begin
      rs_n  = (state_n == LINE1 || state_n == LINE2);
      dat_n = (state_n == INIT_NIB || lo_n) ? nb[3:0] : nb[7:4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PWR_WAIT;
      phase   <= PH_NONE;
      cnt     <= '0;
      idx     <= '0;
      lo      <= 1'b0;
      pending <= 1'b0;
      frame   <= '0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_dat <= 4'h0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      lo      <= lo_n;
      pending <= pending_n;
      frame   <= frame_n;
      lcd_e   <= e_n;
      lcd_rs  <= rs_n;
      lcd_dat <= dat_n;
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// tb/tb_lcd_driver.sv - self-checking bench for lcd_driver against a nibble-level reference model.
module tb_lcd_driver;

  localparam int TP = 20, TS = 2, TE = 3, TN = 4, TC = 10, TCL = 30;

  logic         clk = 1'b0, rst = 1'b1, refresh = 1'b0;
  logic [255:0] strdata = '0;
  logic         busy, lcd_rs, lcd_rw, lcd_e;
  logic [3:0]   lcd_dat;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int bad_width = 0, bad_stable = 0, bad_setup = 0;
  logic [4:0] got_q[$];
  logic [4:0] exp_q[$];
  logic       prev_e = 1'b0;
  logic [4:0] cap = '0, last_v = '0;
  int         hi = 0, stab = 0;

  lcd_driver #(.T_POWERUP(TP), .T_SETUP(TS), .T_EPULSE(TE), .T_NIBBLE(TN),
               .T_CMD(TC), .T_CLEAR(TCL)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .strdata(strdata), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_dat(lcd_dat));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Record each E pulse with its RS/DAT and police width, setup and hold.
  always @(negedge clk) begin
    logic [4:0] v;
    v = {lcd_rs, lcd_dat};
    if (v == last_v) stab++; else stab = 0;
    if (rst) hi = 0;
    else if (lcd_e && !prev_e) begin
      cap = v; got_q.push_back(v); hi = 1;
      if (stab < TS) bad_setup++;
    end else if (lcd_e) begin
      hi++;
      if (v != cap) bad_stable++;
    end else if (prev_e) begin
      if (hi != TE) bad_width++;
      if (v != cap) bad_stable++;
    end
    prev_e = lcd_e;
    last_v = v;
  end

  function automatic int byte_len(int w);
    return 2 * (TS + TE) + TN + w;
  endfunction

  function automatic int init_len();
    return TP + 2 * (TS + TE + TCL) + 2 * (TS + TE + TC) + 3 * byte_len(TC) + byte_len(TCL);
  endfunction

  function automatic int frame_len();
    return 34 * byte_len(TC);
  endfunction

  function automatic logic [7:0] char_of(logic [255:0] s, int i);
    logic [255:0] t;
    t = s >> (8 * (31 - i));
    return t[7:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic add_init();
    logic [47:0] seq, t;
    seq = 48'h3332_2806_0C01;
    for (int i = 0; i < 12; i++) begin
      t = seq >> (4 * (11 - i));
      exp_q.push_back({1'b0, t[3:0]});
    end
  endtask

  task automatic add_frame(input logic [255:0] s);
    add_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) add_byte(1'b1, char_of(s, i));
    add_byte(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) add_byte(1'b1, char_of(s, i));
  endtask

  task automatic cmp_q(input string tag);
    int mism;
    mism = 0;
    check({tag, "_pulse_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_nibble_errors"}, mism, 0);
  endtask

  task automatic wait_busy_low(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin @(posedge clk); #1; n++; end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
  endtask

  task automatic stay_idle(input string tag);
    int hits;
    hits = 0;
    repeat (6) begin @(posedge clk); #1; if (busy) hits++; end
    check({tag, "_stays_idle"}, hits, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_e"}, lcd_e, 0);
    check({tag, "_rs"}, lcd_rs, 0);
    check({tag, "_rw"}, lcd_rw, 0);
    check({tag, "_dat"}, lcd_dat, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Called #1 after the last reset edge.
  task automatic init_check(input string tag);
    int n;
    rst = 1'b0;
    got_q.delete(); exp_q.delete(); add_init();
    n = 0;
    while (lcd_e !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "_first_e_cycle"}, n, TP + TS);
    check({tag, "_first_dat"}, lcd_dat, 4'h3);
    check({tag, "_first_rs"}, lcd_rs, 0);
    while (busy !== 1'b0 && n < 5000) begin @(posedge clk); #1; n++; end
    check({tag, "_busy_fall_cycle"}, n, init_len());
    cmp_q(tag);
  endtask

  initial begin
    int n, g;
    logic [255:0] sa, sb, sc;

    // 1: power-up and init sequence
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t1_reset");
    init_check("t1_init");
    stay_idle("t1");

    // 2: directed frame
    strdata = "0123456789ABCDEFfedcba9876543210";
    got_q.delete(); exp_q.delete(); add_frame(strdata);
    pulse_refresh();
    check("t2_busy_rise", busy, 1);
    wait_busy_low(3000, n);
    check("t2_frame_cycles", n, frame_len());
    cmp_q("t2");
    stay_idle("t2");

    // 3: strdata changes mid-frame
    sa = rnd256();
    strdata = sa;
    got_q.delete(); exp_q.delete(); add_frame(sa);
    pulse_refresh();
    n = 0;
    while (got_q.size() < 10 && n < 1000) begin @(posedge clk); #1; n++; end
    strdata = rnd256();
    wait_busy_low(3000, n);
    check("t3_done", busy, 0);
    cmp_q("t3");
    stay_idle("t3");

    // 4: three refreshes during a frame merge into one more frame
    sa = rnd256(); sb = rnd256(); sc = rnd256();
    strdata = sa;
    got_q.delete(); exp_q.delete(); add_frame(sa); add_frame(sb);
    pulse_refresh();
    repeat (100) @(posedge clk);
    #1; pulse_refresh();
    repeat (50) @(posedge clk);
    #1; pulse_refresh();
    repeat (30) @(posedge clk);
    #1; pulse_refresh();
    strdata = sb;
    wait_busy_low(3000, n);
    g = 0;
    while (busy !== 1'b1 && g < 10) begin @(posedge clk); #1; g++; end
    check("t4_gap_cycles", g, 1);
    strdata = sc;
    wait_busy_low(3000, n);
    check("t4_second_frame_cycles", n, frame_len());
    cmp_q("t4");
    stay_idle("t4");

    // 5: reset during LINE2 with E high
    strdata = rnd256();
    got_q.delete();
    pulse_refresh();
    n = 0;
    while (!(got_q.size() >= 38 && lcd_e === 1'b1) && n < 2000) begin @(posedge clk); #1; n++; end
    check("t5_in_line2_e_high", lcd_e, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t5_reset");
    @(posedge clk); #1;
    init_check("t5_reinit");
    stay_idle("t5");

    // 6a: refresh held through init gives one frame right after init
    sa = rnd256();
    strdata = sa;
    rst = 1'b1; refresh = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    init_check("t6a_init");
    refresh = 1'b0;
    @(posedge clk); #1;
    check("t6a_frame_start", busy, 1);
    add_frame(sa);
    wait_busy_low(3000, n);
    check("t6a_frame_cycles", n, frame_len());
    cmp_q("t6a");
    stay_idle("t6a");

    // 6b: refresh held continuously gives back-to-back frames
    sb = rnd256();
    strdata = sb;
    got_q.delete(); exp_q.delete(); add_frame(sb); add_frame(sb);
    refresh = 1'b1;
    @(posedge clk); #1;
    check("t6b_start", busy, 1);
    wait_busy_low(3000, n);
    check("t6b_frame1_cycles", n, frame_len());
    g = 0;
    while (busy !== 1'b1 && g < 10) begin @(posedge clk); #1; g++; end
    check("t6b_gap_cycles", g, 1);
    refresh = 1'b0;
    wait_busy_low(3000, n);
    check("t6b_frame2_cycles", n, frame_len());
    cmp_q("t6b");
    stay_idle("t6b");

    check("e_width_errors", bad_width, 0);
    check("hold_errors", bad_stable, 0);
    check("setup_errors", bad_setup, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
